cam_stream_gen: RTL and testbench
=================================

CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

Interface
REQ-001 Parameter WIDTH, default 240, active pixels per line (2 bytes each, RGB565).
REQ-002 Parameter HEIGHT, default 240, active lines per frame.
REQ-003 Parameter HBLANK, default 16, PCLK periods with HREF low after each active line.
REQ-004 Parameters VSYNC_LINES=3, VBP_LINES=17, VFP_LINES=10: line counts of VSYNC-high, back porch, front porch.
REQ-005 clk  input  1  system clock; all logic on posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  level; 1 = generate frames continuously.
REQ-008 PCLK  output  1  pixel clock, clk/2 while running.
REQ-009 VSYNC  output  1  frame sync, active high.
REQ-010 HREF  output  1  line valid, active high.
REQ-011 CAM_DATA  output  8  pixel byte.
REQ-012 frame_start  output  1  one-clk pulse when VSYNC rises.
REQ-013 frame_done  output  1  one-clk pulse when front porch ends.
REQ-014 busy  output  1  high from frame_start until frame_done inclusive.

Function
REQ-015 Emulates the OV7670 parallel output side, so the ov7670_controller capture path can run without a sensor.
REQ-016 States: IDLE, VSYNC, VBP, ACTIVE, HBL, VFP.
REQ-017 A line is WIDTH*2+HBLANK PCLK periods; each PCLK period is 2 clk.
REQ-018 In IDLE, PCLK, VSYNC, HREF and CAM_DATA are held 0.
REQ-019 IDLE->VSYNC when enable=1; frame_start pulses on that clk; PCLK starts toggling on the next clk.
REQ-020 VSYNC is high for VSYNC_LINES lines, then VBP for VBP_LINES lines, with HREF=0 and CAM_DATA=0 throughout.
REQ-021 ACTIVE: HREF=1 for WIDTH*2 PCLK periods; then HBL: HREF=0 for HBLANK periods; repeat for HEIGHT lines; then VFP.
REQ-022 Outputs (VSYNC, HREF, CAM_DATA) change only on the clk where PCLK goes 1->0, so they are stable at the PCLK rising edge.
REQ-023 Pixel word for column x, line y is {y[7:0], x[7:0]}; high byte is sent first, then low byte; x and y restart at 0 per line and per frame.
REQ-024 After VFP_LINES lines, frame_done pulses; next state is VSYNC if enable=1, else IDLE with PCLK low.
REQ-025 Deasserting enable mid-frame does not truncate the frame; the current frame completes.
REQ-026 An 8-bit frame counter increments at each frame_done and wraps 255->0.
REQ-027 Line and pixel counters are wide enough for the parameter values; there is no modulo-256 aliasing of line length.

Reset
REQ-028 Reset asserted at any time, including mid-line, forces IDLE, all outputs 0, all counters 0 and frame counter 0 on the same clk.
REQ-029 After reset release, the first frame_start occurs on the first clk with enable=1.

Configuration
REQ-030 Macro CAM_STREAM_GEN_FRAME_ID_EN: when defined, the first pixel word of each frame (x=0,y=0) is replaced by {8'hA5, frame_counter}.
REQ-031 When CAM_STREAM_GEN_FRAME_ID_EN is not defined, the first pixel follows REQ-023, and the frame counter logic is omitted.

Verification
REQ-032 Use WIDTH=4, HEIGHT=2, HBLANK=2, VSYNC_LINES=1, VBP_LINES=1, VFP_LINES=1. With enable held at 1, the bench shall see frame_start then frame_done 5 lines x 10 PCLK = 100 clk later; exactly 8 bytes per HREF pulse; 2 HREF pulses per frame.
REQ-033 Sample CAM_DATA on PCLK rising edges during HREF. Line 1 shall give 01,00,01,01,01,02,01,03 (without the macro).
REQ-034 With the macro defined, frame 0 shall start with bytes A5,00 and frame 1 with A5,01. Without the macro, both frames shall start with 00,00.
REQ-035 Drop enable in the middle of line 0. The frame shall complete with frame_done, then IDLE with PCLK=0; no further frame_start shall occur.
REQ-036 Assert reset during an HREF-high period. On the same clk, HREF=0, PCLK=0 and busy=0. After release with enable=1, the next frame shall start at x=0, y=0.
REQ-037 Feed the output into ov7670_controller with default parameters. The controller shall report 240x240 words with values equal to REQ-023.

Source files
------------

// File: rtl/cam_stream_gen_if.sv
// OV7670-style parallel camera bus: pixel clock, syncs and byte lane.
interface cam_stream_gen_if;
  logic       PCLK;
  logic       VSYNC;
  logic       HREF;
  logic [7:0] CAM_DATA;

  modport master (output PCLK, VSYNC, HREF, CAM_DATA);
  modport slave  (input  PCLK, VSYNC, HREF, CAM_DATA);
endinterface

// File: rtl/cam_stream_gen.sv
// Synthetic OV7670 output stream (RGB565, word {y[7:0], x[7:0]}) for sensorless capture tests.
// Optional macro CAM_STREAM_GEN_FRAME_ID_EN replaces pixel (0,0) with {8'hA5, frame_counter}.
module cam_stream_gen #(
  parameter int WIDTH       = 240,
  parameter int HEIGHT      = 240,
  parameter int HBLANK      = 16,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  cam_stream_gen_if.master  cam,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy
);

  localparam int ACT_LEN  = 2 * WIDTH;
  localparam int LINE_LEN = ACT_LEN + HBLANK;
  localparam int PCNT_W   = $clog2(LINE_LEN + 1);
  localparam int LMAX_A   = (HEIGHT > VSYNC_LINES) ? HEIGHT : VSYNC_LINES;
  localparam int LMAX_B   = (VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES;
  localparam int LMAX     = (LMAX_A > LMAX_B) ? LMAX_A : LMAX_B;
  localparam int LCNT_W   = $clog2(LMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_HBL,
    ST_VFP
  } state_t;

  state_t              state, state_n;
  logic [PCNT_W-1:0]   pcnt, pcnt_n;
  logic [LCNT_W-1:0]   lcnt, lcnt_n;
  logic                pclk_q, pclk_n;
  logic                vsync_q, vsync_n;
  logic                href_q, href_n;
  logic [7:0]          data_q, data_n;
  logic                start_q, start_n;
  logic                done_q, done_n;
  logic                adv;
  logic                line_end;

`ifdef CAM_STREAM_GEN_FRAME_ID_EN
  logic [7:0]          fcnt, fcnt_n;
`endif

  assign cam.PCLK     = pclk_q;
  assign cam.VSYNC    = vsync_q;
  assign cam.HREF     = href_q;
  assign cam.CAM_DATA = data_q;
  assign frame_start  = start_q;
  assign frame_done   = done_q;
  assign busy         = (state != ST_IDLE) || done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      pcnt    <= '0;
      lcnt    <= '0;
      pclk_q  <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      pcnt    <= pcnt_n;
      lcnt    <= lcnt_n;
      pclk_q  <= pclk_n;
      vsync_q <= vsync_n;
      href_q  <= href_n;
      data_q  <= data_n;
      start_q <= start_n;
      done_q  <= done_n;
    end
  end

`ifdef CAM_STREAM_GEN_FRAME_ID_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fcnt <= '0;
    else       fcnt <= fcnt_n;
  end
`endif

  // Position (state, pcnt, lcnt) advances one PCLK period on each PCLK 1->0 clk;
  // the outputs for the new period are registered on that same clk.
  always_comb begin
    state_n  = state;
    pcnt_n   = pcnt;
    lcnt_n   = lcnt;
    pclk_n   = pclk_q;
    vsync_n  = vsync_q;
    href_n   = href_q;
    data_n   = data_q;
    start_n  = 1'b0;
    done_n   = 1'b0;
    adv      = 1'b0;
    line_end = (pcnt == PCNT_W'(LINE_LEN - 1));
`ifdef CAM_STREAM_GEN_FRAME_ID_EN
    fcnt_n   = fcnt;
`endif

    if (state == ST_IDLE) begin
      pclk_n = 1'b0;
      if (enable) begin
        state_n = ST_VSYNC;
        pcnt_n  = '0;
        lcnt_n  = '0;
        start_n = 1'b1;
        adv     = 1'b1;
      end
    end else if (!pclk_q) begin
      pclk_n = 1'b1;
    end else begin
      pclk_n = 1'b0;
      adv    = 1'b1;
      pcnt_n = line_end ? '0 : pcnt + PCNT_W'(1);
      unique case (state)
        ST_VSYNC: if (line_end) begin
          if (lcnt == LCNT_W'(VSYNC_LINES - 1)) begin
            state_n = ST_VBP;
            lcnt_n  = '0;
          end else lcnt_n = lcnt + LCNT_W'(1);
        end
        ST_VBP: if (line_end) begin
          if (lcnt == LCNT_W'(VBP_LINES - 1)) begin
            state_n = ST_ACTIVE;
            lcnt_n  = '0;
          end else lcnt_n = lcnt + LCNT_W'(1);
        end
        ST_ACTIVE: if (pcnt == PCNT_W'(ACT_LEN - 1)) state_n = ST_HBL;
        ST_HBL: if (line_end) begin
          if (lcnt == LCNT_W'(HEIGHT - 1)) begin
            state_n = ST_VFP;
            lcnt_n  = '0;
          end else begin
            state_n = ST_ACTIVE;
            lcnt_n  = lcnt + LCNT_W'(1);
          end
        end
        ST_VFP: if (line_end) begin
          if (lcnt == LCNT_W'(VFP_LINES - 1)) begin
            done_n = 1'b1;
            lcnt_n = '0;
`ifdef CAM_STREAM_GEN_FRAME_ID_EN
            fcnt_n = fcnt + 8'd1;
`endif
            if (enable) begin
              state_n = ST_VSYNC;
              start_n = 1'b1;
            end else state_n = ST_IDLE;
          end else lcnt_n = lcnt + LCNT_W'(1);
        end
        default: state_n = ST_IDLE;
      endcase
    end

    if (adv) begin
      vsync_n = (state_n == ST_VSYNC);
      href_n  = (state_n == ST_ACTIVE);
      data_n  = '0;
      if (state_n == ST_ACTIVE) begin
        data_n = pcnt_n[0] ? 8'(pcnt_n >> 1) : 8'(lcnt_n);
`ifdef CAM_STREAM_GEN_FRAME_ID_EN
        if (lcnt_n == '0 && pcnt_n < PCNT_W'(2))
          data_n = pcnt_n[0] ? fcnt : 8'hA5;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Randomised bench for cam_stream_gen against a frame-level byte-stream model.
module tb_cam_stream_gen;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HB = 2;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int LINE_CLK  = 2 * (2 * W + HB);
  localparam int FRAME_CLK = (VS + VB + H + VF) * LINE_CLK;
  localparam int BPF       = 2 * W * H;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic frame_start, frame_done, busy;

  cam_stream_gen_if cam ();

  cam_stream_gen #(
    .WIDTH(W), .HEIGHT(H), .HBLANK(HB),
    .VSYNC_LINES(VS), .VBP_LINES(VB), .VFP_LINES(VF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .cam(cam),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int fs_q[$];
  int fd_q[$];
  int hp_q[$];
  int vs_q[$];
  logic [7:0] byte_q[$];
  logic pclk_prev = 1'b0, href_prev = 1'b0, vs_prev = 1'b0;
  int cur_cnt = 0, vs_len = 0, pclk_edges = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_start === 1'b1) fs_q.push_back(cyc);
    if (frame_done === 1'b1) fd_q.push_back(cyc);
    if (cam.PCLK !== pclk_prev) pclk_edges++;
    if (cam.PCLK === 1'b1 && pclk_prev === 1'b0 && cam.HREF === 1'b1) begin
      byte_q.push_back(cam.CAM_DATA);
      cur_cnt++;
    end
    if (cam.HREF === 1'b0 && href_prev === 1'b1) begin
      hp_q.push_back(cur_cnt);
      cur_cnt = 0;
    end
    if (cam.VSYNC === 1'b1) vs_len++;
    else if (vs_prev === 1'b1) begin
      vs_q.push_back(vs_len);
      vs_len = 0;
    end
    pclk_prev = cam.PCLK;
    href_prev = cam.HREF;
    vs_prev   = cam.VSYNC;
  end

  // Expected byte idx (0..BPF-1) of frame fid: raster order, high byte first.
  function automatic logic [7:0] exp_byte(input int fid, input int idx);
    int line, col;
    logic [15:0] word;
    logic use_id;
    use_id = 1'b0;
`ifdef CAM_STREAM_GEN_FRAME_ID_EN
    use_id = 1'b1;
`endif
    line = idx / (2 * W);
    col  = (idx % (2 * W)) / 2;
    word = {8'(line), 8'(col)};
    if (use_id && line == 0 && col == 0) word = {8'hA5, 8'(fid)};
    return (idx % 2 == 0) ? word[15:8] : word[7:0];
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    fs_q.delete(); fd_q.delete(); hp_q.delete(); vs_q.delete(); byte_q.delete();
    pclk_prev = cam.PCLK; href_prev = cam.HREF; vs_prev = cam.VSYNC;
    cur_cnt = 0; vs_len = 0; pclk_edges = 0;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    reset  = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int k = 0;
    while (fd_q.size() < n && k < budget) begin tick(); k++; end
    ok = (fd_q.size() >= n);
  endtask

  task automatic wait_href(input int budget, output bit ok);
    int k = 0;
    while (cam.HREF !== 1'b1 && k < budget) begin tick(); k++; end
    ok = (cam.HREF === 1'b1);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin tick(); k++; end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    tick();
    total++; if ({cam.PCLK, cam.VSYNC, cam.HREF} !== 3'b000) begin bad++; $display("FAIL reset_sync: got %b expected 000", {cam.PCLK, cam.VSYNC, cam.HREF}); end
    total++; if (cam.CAM_DATA !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", cam.CAM_DATA); end
    total++; if ({frame_start, frame_done, busy} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b expected 000", {frame_start, frame_done, busy}); end
    reset = 1'b0;
    clear_mon();
    repeat (30) tick();
    total++; if (pclk_edges !== 0) begin bad++; $display("FAIL idle_pclk_edges: got %0d expected 0", pclk_edges); end
    total++; if (fs_q.size() !== 0 || busy !== 1'b0) begin bad++; $display("FAIL idle_no_start: got starts=%0d busy=%b expected 0/0", fs_q.size(), busy); end
  endtask

  task automatic test_continuous();
    bit ok;
    int nf;
    logic [7:0] line1 [8];
    line1 = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h03};
    do_reset();
    enable = 1'b1;
    tick();
    total++; if ({frame_start, cam.VSYNC, cam.PCLK, busy} !== 4'b1101) begin bad++; $display("FAIL first_start: got %b expected 1101", {frame_start, cam.VSYNC, cam.PCLK, busy}); end
    tick();
    total++; if ({cam.PCLK, frame_start} !== 2'b10) begin bad++; $display("FAIL pclk_starts: got %b expected 10", {cam.PCLK, frame_start}); end
    wait_frames(2, 3 * FRAME_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL cont_timeout: got %0d frames expected 2", fd_q.size()); end
    enable = 1'b0;
    wait_idle(3 * FRAME_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL cont_idle_timeout: got busy=%b expected 0", busy); end
    nf = fs_q.size();
    total++; if (fd_q.size() !== nf || nf < 2) begin bad++; $display("FAIL cont_counts: got starts=%0d dones=%0d expected equal and >=2", nf, fd_q.size()); end
    for (int i = 0; i < nf && i < fd_q.size(); i++) begin
      total++; if (fd_q[i] - fs_q[i] !== FRAME_CLK) begin bad++; $display("FAIL cont_frame_len[%0d]: got %0d expected %0d", i, fd_q[i] - fs_q[i], FRAME_CLK); end
      if (i > 0) begin
        total++; if (fs_q[i] !== fd_q[i-1]) begin bad++; $display("FAIL cont_back_to_back[%0d]: got %0d expected %0d", i, fs_q[i], fd_q[i-1]); end
      end
    end
    total++; if (hp_q.size() !== 2 * nf) begin bad++; $display("FAIL cont_href_pulses: got %0d expected %0d", hp_q.size(), 2 * nf); end
    foreach (hp_q[i]) begin
      total++; if (hp_q[i] !== 2 * W) begin bad++; $display("FAIL cont_bytes_per_line[%0d]: got %0d expected %0d", i, hp_q[i], 2 * W); end
    end
    foreach (vs_q[i]) begin
      total++; if (vs_q[i] !== VS * LINE_CLK) begin bad++; $display("FAIL cont_vsync_len[%0d]: got %0d expected %0d", i, vs_q[i], VS * LINE_CLK); end
    end
    total++; if (byte_q.size() !== BPF * nf) begin bad++; $display("FAIL cont_byte_count: got %0d expected %0d", byte_q.size(), BPF * nf); end
    for (int i = 0; i < byte_q.size() && i < BPF * nf; i++) begin
      total++; if (byte_q[i] !== exp_byte(i / BPF, i % BPF)) begin bad++; $display("FAIL cont_byte[%0d]: got %h expected %h", i, byte_q[i], exp_byte(i / BPF, i % BPF)); end
    end
    for (int i = 0; i < 8 && 8 + i < byte_q.size(); i++) begin
      total++; if (byte_q[8 + i] !== line1[i]) begin bad++; $display("FAIL line1_byte[%0d]: got %h expected %h", i, byte_q[8 + i], line1[i]); end
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    do_reset();
    enable = 1'b1;
    wait_href(4 * FRAME_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_href_timeout: got HREF=%b expected 1", cam.HREF); end
    repeat ($urandom_range(0, 12)) tick();
    enable = 1'b0;
    wait_frames(1, 2 * FRAME_CLK, ok);
    total++; if (!ok || frame_done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL drop_done: got ok=%b done=%b busy=%b expected 1/1/1", ok, frame_done, busy); end
    tick();
    total++; if ({busy, cam.PCLK, cam.VSYNC, cam.HREF} !== 4'b0000) begin bad++; $display("FAIL drop_idle: got %b expected 0000", {busy, cam.PCLK, cam.VSYNC, cam.HREF}); end
    repeat (3 * FRAME_CLK) tick();
    total++; if (fs_q.size() !== 1 || cam.PCLK !== 1'b0) begin bad++; $display("FAIL drop_no_restart: got starts=%0d pclk=%b expected 1/0", fs_q.size(), cam.PCLK); end
    total++; if (byte_q.size() !== BPF) begin bad++; $display("FAIL drop_byte_count: got %0d expected %0d", byte_q.size(), BPF); end
    for (int i = 0; i < byte_q.size() && i < BPF; i++) begin
      total++; if (byte_q[i] !== exp_byte(0, i)) begin bad++; $display("FAIL drop_byte[%0d]: got %h expected %h", i, byte_q[i], exp_byte(0, i)); end
    end
  endtask

  task automatic test_reset_mid_href();
    bit ok;
    do_reset();
    enable = 1'b1;
    wait_frames(1, 2 * FRAME_CLK, ok);
    wait_href(2 * FRAME_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL rst_href_timeout: got HREF=%b expected 1", cam.HREF); end
    repeat ($urandom_range(0, 10)) tick();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++; if ({cam.HREF, cam.PCLK, busy, cam.VSYNC} !== 4'b0000) begin bad++; $display("FAIL rst_async_outputs: got %b expected 0000", {cam.HREF, cam.PCLK, busy, cam.VSYNC}); end
    total++; if (cam.CAM_DATA !== 8'h00) begin bad++; $display("FAIL rst_async_data: got %h expected 00", cam.CAM_DATA); end
    tick();
    clear_mon();
    reset = 1'b0;
    tick();
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL rst_restart: got %b expected 1", frame_start); end
    wait_frames(1, 2 * FRAME_CLK, ok);
    enable = 1'b0;
    total++; if (byte_q.size() !== BPF) begin bad++; $display("FAIL rst_byte_count: got %0d expected %0d", byte_q.size(), BPF); end
    for (int i = 0; i < byte_q.size() && i < BPF; i++) begin
      total++; if (byte_q[i] !== exp_byte(0, i)) begin bad++; $display("FAIL rst_byte[%0d]: got %h expected %h", i, byte_q[i], exp_byte(0, i)); end
    end
    wait_idle(2 * FRAME_CLK, ok);
  endtask

  task automatic test_random_enable();
    bit ok;
    int nf;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      enable = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 150)) tick();
    end
    enable = 1'b0;
    wait_idle(2 * FRAME_CLK, ok);
    total++; if (!ok) begin bad++; $display("FAIL rand_idle_timeout: got busy=%b expected 0", busy); end
    nf = fs_q.size();
    total++; if (fd_q.size() !== nf) begin bad++; $display("FAIL rand_counts: got starts=%0d dones=%0d expected equal", nf, fd_q.size()); end
    for (int i = 0; i < nf && i < fd_q.size(); i++) begin
      total++; if (fd_q[i] - fs_q[i] !== FRAME_CLK) begin bad++; $display("FAIL rand_frame_len[%0d]: got %0d expected %0d", i, fd_q[i] - fs_q[i], FRAME_CLK); end
    end
    total++; if (hp_q.size() !== 2 * nf) begin bad++; $display("FAIL rand_href_pulses: got %0d expected %0d", hp_q.size(), 2 * nf); end
    total++; if (byte_q.size() !== BPF * nf) begin bad++; $display("FAIL rand_byte_count: got %0d expected %0d", byte_q.size(), BPF * nf); end
    for (int i = 0; i < byte_q.size() && i < BPF * nf; i++) begin
      total++; if (byte_q[i] !== exp_byte(i / BPF, i % BPF)) begin bad++; $display("FAIL rand_byte[%0d]: got %h expected %h", i, byte_q[i], exp_byte(i / BPF, i % BPF)); end
    end
  endtask

  task automatic test_frame_wrap();
    bit ok;
    int fr [3];
    fr = '{0, 255, 256};
    do_reset();
    enable = 1'b1;
    wait_frames(257, 257 * FRAME_CLK + 50, ok);
    enable = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: got %0d frames expected 257", fd_q.size()); end
    wait_idle(2 * FRAME_CLK, ok);
    total++; if (byte_q.size() < 257 * BPF) begin bad++; $display("FAIL wrap_byte_count: got %0d expected >= %0d", byte_q.size(), 257 * BPF); end
    foreach (fr[k]) begin
      for (int b = 0; b < 2; b++) begin
        if (fr[k] * BPF + b < byte_q.size()) begin
          total++; if (byte_q[fr[k] * BPF + b] !== exp_byte(fr[k], b)) begin bad++; $display("FAIL wrap_frame%0d_byte%0d: got %h expected %h", fr[k], b, byte_q[fr[k] * BPF + b], exp_byte(fr[k], b)); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_enable_drop();
    test_reset_mid_href();
    test_random_enable();
    test_frame_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
